// File: rtl/round_sequencer.sv
`default_nettype none
// =============================================================================
// round_sequencer
// Round-level controller for the memory game: paces sequence playback, times
// the user input window, grades keys and grows the round until win or loss.
// Revision: 1.0
// =============================================================================
module round_sequencer #(
  parameter int TICK_DIV      = 50_000_000,
  parameter int SHOW_TICKS    = 1,
  parameter int TIMEOUT_TICKS = 5,
  parameter int N_ROUNDS      = 16,
  parameter int ADDR_W        = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enter,
  input  logic              key_valid,
  input  logic              match,
  output logic              load_seq,
  output logic [ADDR_W-1:0] seq_addr,
  output logic              show,
  output logic              user_en,
  output logic [ADDR_W:0]   round,
  output logic [7:0]        time_left,
  output logic              win,
  output logic              lose,
  output logic [2:0]        state
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TW = (SHOW_TICKS > 1) ? $clog2(SHOW_TICKS) : 1;

  localparam logic [PW-1:0]   TICK_MAX  = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0]   SHOW_LAST = TW'(SHOW_TICKS - 1);
  localparam logic [7:0]      TOUT      = 8'(TIMEOUT_TICKS);
  localparam logic [ADDR_W:0] ROUND_MAX = (ADDR_W + 1)'(N_ROUNDS);
  localparam logic [ADDR_W:0] ROUND_ONE = (ADDR_W + 1)'(1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_SHOW = 3'd2,
    S_GAP  = 3'd3,
    S_WAIT = 3'd4,
    S_WIN  = 3'd5,
    S_LOSE = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic              enter_q;
  logic [PW-1:0]     cnt_q, cnt_d;
  logic [TW-1:0]     ticks_q, ticks_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   round_q, round_d;
  logic [7:0]        tleft_q, tleft_d;
  logic              load_q, load_d;
  logic              show_q, show_d;
  logic              user_q, user_d;
  logic              win_q, win_d;
  logic              lose_q, lose_d;

  logic start;
  logic tick;
  logic last_addr;
  logic restart;

  assign start     = enter & ~enter_q;
  assign tick      = (cnt_q == TICK_MAX);
  assign last_addr = ({1'b0, addr_q} == (round_q - ROUND_ONE));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    round_d = round_q;
    tleft_d = tleft_q;
    restart = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          round_d = ROUND_ONE;
          addr_d  = '0;
        end
      end

      S_LOAD: begin
        state_d = S_SHOW;
        addr_d  = '0;
      end

      S_SHOW: begin
        if (tick && (ticks_q == SHOW_LAST)) begin
          state_d = S_GAP;
        end
      end

      S_GAP: begin
        if (tick) begin
          if (last_addr) begin
            state_d = S_WAIT;
            addr_d  = '0;
            tleft_d = TOUT;
          end else begin
            state_d = S_SHOW;
            addr_d  = addr_q + ADDR_W'(1);
          end
        end
      end

      S_WAIT: begin
        // A key in the same cycle as the expiring tick is graded; the timeout loses.
        if (key_valid) begin
          if (!match) begin
            state_d = S_LOSE;
          end else if (!last_addr) begin
            addr_d  = addr_q + ADDR_W'(1);
            tleft_d = TOUT;
            restart = 1'b1;
          end else if (round_q == ROUND_MAX) begin
            state_d = S_WIN;
          end else begin
            state_d = S_SHOW;
            round_d = round_q + ROUND_ONE;
            addr_d  = '0;
            tleft_d = '0;
          end
        end else if (tick) begin
          if (tleft_q == 8'd1) begin
            state_d = S_LOSE;
            tleft_d = '0;
          end else begin
            tleft_d = tleft_q - 8'd1;
          end
        end
      end

      S_WIN, S_LOSE: begin
        if (start) begin
          state_d = S_IDLE;
          round_d = '0;
          addr_d  = '0;
          tleft_d = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
        round_d = '0;
        addr_d  = '0;
        tleft_d = '0;
      end
    endcase

    if ((state_d != state_q) || restart) begin
      cnt_d   = '0;
      ticks_d = '0;
    end else begin
      cnt_d   = tick ? '0 : cnt_q + PW'(1);
      ticks_d = tick ? ticks_q + TW'(1) : ticks_q;
    end

    load_d = (state_d == S_LOAD);
    show_d = (state_d == S_SHOW);
    user_d = (state_d == S_WAIT);
    win_d  = (state_d == S_WIN);
    lose_d = (state_d == S_LOSE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      enter_q <= 1'b0;
      cnt_q   <= '0;
      ticks_q <= '0;
      addr_q  <= '0;
      round_q <= '0;
      tleft_q <= '0;
      load_q  <= 1'b0;
      show_q  <= 1'b0;
      user_q  <= 1'b0;
      win_q   <= 1'b0;
      lose_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      enter_q <= enter;
      cnt_q   <= cnt_d;
      ticks_q <= ticks_d;
      addr_q  <= addr_d;
      round_q <= round_d;
      tleft_q <= tleft_d;
      load_q  <= load_d;
      show_q  <= show_d;
      user_q  <= user_d;
      win_q   <= win_d;
      lose_q  <= lose_d;
    end
  end

  assign load_seq  = load_q;
  assign seq_addr  = addr_q;
  assign show      = show_q;
  assign user_en   = user_q;
  assign round     = round_q;
  assign time_left = tleft_q;
  assign win       = win_q;
  assign lose      = lose_q;
  assign state     = state_q;

endmodule
`default_nettype wire

// File: tb/tb_round_sequencer.sv
`default_nettype none
// =============================================================================
// tb_round_sequencer
// Vector-table bench: expected per-cycle outputs queued with each stimulus.
// Revision: 1.1
// =============================================================================
module tb_round_sequencer;

    logic       r_clk = 1'b0;
    logic       r_rst = 1'b1;
    logic       r_enter = 1'b0;
    logic       r_key_valid = 1'b0;
    logic       r_match = 1'b0;
    logic       w_load_seq;
    logic [3:0] w_seq_addr;
    logic       w_show;
    logic       w_user_en;
    logic [4:0] w_round;
    logic [7:0] w_time_left;
    logic       w_win;
    logic       w_lose;
    logic [2:0] w_state;

    round_sequencer #(
        .TICK_DIV     (4),
        .SHOW_TICKS   (2),
        .TIMEOUT_TICKS(3),
        .N_ROUNDS     (3),
        .ADDR_W       (4)
    ) dut (
        .clock    (r_clk),
        .reset    (r_rst),
        .enter    (r_enter),
        .key_valid(r_key_valid),
        .match    (r_match),
        .load_seq (w_load_seq),
        .seq_addr (w_seq_addr),
        .show     (w_show),
        .user_en  (w_user_en),
        .round    (w_round),
        .time_left(w_time_left),
        .win      (w_win),
        .lose     (w_lose),
        .state    (w_state)
    );

    always #5 r_clk = ~r_clk;

    typedef struct {
        string      tag;
        logic       rst, en, kv, mt;
        logic [2:0] st;
        logic       ld, sh, ue;
        logic [3:0] a;
        logic [4:0] r;
        logic [7:0] tl;
        logic       tlx;
        logic       w, l;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   r_n_vec = 0;
    int   r_n_bad = 0;

    function automatic void add(int n, string tag, int rst, int en, int kv, int mt,
                                int st, int ld, int sh, int ue, int a, int r,
                                int tl, int tlx, int w, int l);
        vec_t v;
        v.tag = tag;
        v.rst = (rst != 0);  v.en = (en != 0);  v.kv = (kv != 0);  v.mt = (mt != 0);
        v.st  = 3'(st);      v.ld = (ld != 0);  v.sh = (sh != 0);  v.ue = (ue != 0);
        v.a   = 4'(a);       v.r  = 5'(r);      v.tl = 8'(tl);     v.tlx = (tlx != 0);
        v.w   = (w != 0);    v.l  = (l != 0);
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endfunction

    // Playback of round r: 8 cycles SHOW then 4 cycles GAP per symbol.
    // kfirst: matching key on the first vector; ign: ignored mismatch key on the second.
    function automatic void play(int r, int en, int kfirst, int ign);
        for (int a = 0; a < r; a++) begin
            add(1, "show", 0, en, (a == 0) ? kfirst : 0, (a == 0) ? kfirst : 0, 2, 0, 1, 0, a, r, 0, 1, 0, 0);
            add(1, "show", 0, en, (a == 0) ? ign : 0, 0, 2, 0, 1, 0, a, r, 0, 1, 0, 0);
            add(6, "show", 0, en, 0, 0, 2, 0, 1, 0, a, r, 0, 1, 0, 0);
            add(4, "gap",  0, en, 0, 0, 3, 0, 0, 0, a, r, 0, 1, 0, 0);
        end
    endfunction

    function automatic void idle(int n, string tag, int rst, int en);
        add(n, tag, rst, en, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic void load();
        add(1, "load", 0, 1, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    endfunction

    initial begin
        vec_t e;

        // reset, then reset in the middle of SHOW
        idle(2, "reset", 1, 0);
        idle(1, "idle", 0, 0);
        load();
        add(3, "show_pre", 0, 1, 0, 0, 2, 0, 1, 0, 0, 1, 0, 1, 0, 0);
        idle(2, "rst_mid", 1, 0);
        idle(3, "idle_after_rst", 0, 0);

        // round 1 with no key: timeout countdown then loss
        load();
        play(1, 1, 0, 0);
        add(4, "wait_tl3", 0, 1, 0, 0, 4, 0, 0, 1, 0, 1, 3, 0, 0, 0);
        add(4, "wait_tl2", 0, 1, 0, 0, 4, 0, 0, 1, 0, 1, 2, 0, 0, 0);
        add(4, "wait_tl1", 0, 1, 0, 0, 4, 0, 0, 1, 0, 1, 1, 0, 0, 0);
        add(1, "timeout", 0, 1, 0, 0, 6, 0, 0, 0, 0, 1, 0, 0, 0, 1);
        add(2, "lose_hold", 0, 0, 1, 1, 6, 0, 0, 0, 0, 1, 0, 0, 0, 1);
        idle(1, "exit_lose", 0, 1);
        idle(1, "idle", 0, 0);

        // round 1 correct, round 2 mismatch on second key
        load();
        play(1, 1, 0, 0);
        add(1, "wait_r1", 0, 1, 0, 0, 4, 0, 0, 1, 0, 1, 3, 0, 0, 0);
        play(2, 1, 1, 1);
        add(1, "wait_r2", 0, 1, 0, 0, 4, 0, 0, 1, 0, 2, 3, 0, 0, 0);
        add(1, "key_ok", 0, 1, 1, 1, 4, 0, 0, 1, 1, 2, 3, 0, 0, 0);
        add(1, "key_bad", 0, 1, 1, 0, 6, 0, 0, 0, 1, 2, 0, 1, 0, 1);
        add(2, "lose_keys", 0, 1, 1, 1, 6, 0, 0, 0, 1, 2, 0, 1, 0, 1);
        add(1, "lose_enlow", 0, 0, 0, 0, 6, 0, 0, 0, 1, 2, 0, 1, 0, 1);
        idle(1, "exit_lose2", 0, 1);
        idle(1, "idle", 0, 0);

        // full win: first key lands on the expiring tick
        load();
        play(1, 1, 0, 0);
        add(4, "wait_tl3", 0, 1, 0, 0, 4, 0, 0, 1, 0, 1, 3, 0, 0, 0);
        add(4, "wait_tl2", 0, 1, 0, 0, 4, 0, 0, 1, 0, 1, 2, 0, 0, 0);
        add(4, "wait_tl1", 0, 1, 0, 0, 4, 0, 0, 1, 0, 1, 1, 0, 0, 0);
        play(2, 1, 1, 0);
        add(1, "wait_r2", 0, 1, 0, 0, 4, 0, 0, 1, 0, 2, 3, 0, 0, 0);
        add(1, "key_r2a", 0, 1, 1, 1, 4, 0, 0, 1, 1, 2, 3, 0, 0, 0);
        play(3, 1, 1, 0);
        add(1, "wait_r3", 0, 1, 0, 0, 4, 0, 0, 1, 0, 3, 3, 0, 0, 0);
        add(1, "key_r3a", 0, 1, 1, 1, 4, 0, 0, 1, 1, 3, 3, 0, 0, 0);
        add(1, "key_r3b", 0, 1, 1, 1, 4, 0, 0, 1, 2, 3, 3, 0, 0, 0);
        add(1, "win", 0, 1, 1, 1, 5, 0, 0, 0, 2, 3, 0, 1, 1, 0);
        add(2, "win_hold", 0, 1, 1, 1, 5, 0, 0, 0, 2, 3, 0, 1, 1, 0);
        add(1, "win_enlow", 0, 0, 0, 0, 5, 0, 0, 0, 2, 3, 0, 1, 1, 0);
        idle(1, "exit_win", 0, 1);
        idle(2, "idle_end", 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge r_clk);
            r_rst       = vecs[i].rst;
            r_enter     = vecs[i].en;
            r_key_valid = vecs[i].kv;
            r_match     = vecs[i].mt;
            sb.push_back(vecs[i]);
            @(posedge r_clk);
            #1;
            e = sb.pop_front();
            r_n_vec++;
            if (w_state !== e.st || w_load_seq !== e.ld || w_show !== e.sh || w_user_en !== e.ue ||
                w_seq_addr !== e.a || w_round !== e.r || w_win !== e.w || w_lose !== e.l ||
                (!e.tlx && w_time_left !== e.tl)) begin
                r_n_bad++;
                $display("FAIL %s vec %0d: got st=%0d ld=%0b sh=%0b ue=%0b a=%0d r=%0d tl=%0d w=%0b l=%0b; want st=%0d ld=%0b sh=%0b ue=%0b a=%0d r=%0d tl=%0d%s w=%0b l=%0b",
                         e.tag, i, w_state, w_load_seq, w_show, w_user_en, w_seq_addr, w_round,
                         w_time_left, w_win, w_lose,
                         e.st, e.ld, e.sh, e.ue, e.a, e.r, e.tl, e.tlx ? "(any)" : "", e.w, e.l);
            end
            if (e.tag == "rst_mid") begin
                if (w_state !== 3'd0 || w_load_seq !== 1'b0 || w_show !== 1'b0 ||
                    w_user_en !== 1'b0 || w_seq_addr !== 4'd0 || w_round !== 5'd0 ||
                    w_time_left !== 8'd0 || w_win !== 1'b0 || w_lose !== 1'b0) begin
                    r_n_bad++;
                    $display("FAIL reset-state vec %0d: outputs not all zero (st=%0d a=%0d r=%0d tl=%0d)",
                             i, w_state, w_seq_addr, w_round, w_time_left);
                end
            end
            if (e.tag == "timeout") begin
                if (w_state !== 3'd6 || w_lose !== 1'b1 || w_time_left !== 8'd0 ||
                    w_user_en !== 1'b0) begin
                    r_n_bad++;
                    $display("FAIL expired-wait vec %0d: st=%0d lose=%0b tl=%0d ue=%0b",
                             i, w_state, w_lose, w_time_left, w_user_en);
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", r_n_vec, r_n_bad);
        $finish;
    end

endmodule
`default_nettype wire
